// File: rtl/mem_arbiter.sv
// Two-master arbiter in front of a shared single-port memory.
// A data-stage master and an instruction-fetch master compete for the memory.
// Data has priority, but fetch is granted once data has taken STARVE_LIMIT
// consecutive grants while a fetch was waiting.
module mem_arbiter #(
    parameter int unsigned AW           = 32,
    parameter int unsigned DW           = 32,
    parameter int unsigned STARVE_LIMIT = 4
) (
    input  logic          clk,
    input  logic          reset,
    // instruction-fetch master
    input  logic          i_req,
    input  logic [AW-1:0] i_addr,
    output logic [DW-1:0] i_rdata,
    output logic          i_ready,
    // data-stage master
    input  logic          d_req,
    input  logic          d_we,
    input  logic [AW-1:0] d_addr,
    input  logic [DW-1:0] d_wdata,
    output logic [DW-1:0] d_rdata,
    output logic          d_ready,
    // shared memory port
    output logic          m_req,
    output logic          m_we,
    output logic [AW-1:0] m_addr,
    output logic [DW-1:0] m_wdata,
    input  logic [DW-1:0] m_rdata,
    input  logic          m_ack
);

    localparam int unsigned CW = $clog2(STARVE_LIMIT + 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        IBUSY = 2'd1,
        DBUSY = 2'd2
    } state_t;

    state_t        state;
    logic [CW-1:0] starveCnt;

    logic fetchElig;
    logic dataElig;
    logic grantData;
    logic grantFetch;

    // A master whose ready pulse is showing is still holding its old request.
    assign fetchElig  = i_req & ~i_ready;
    assign dataElig   = d_req & ~d_ready;
    assign grantData  = dataElig & (~fetchElig | (starveCnt < CW'(STARVE_LIMIT)));
    assign grantFetch = fetchElig & ~grantData;

    // Arbitration FSM with registered memory-side and master-side outputs.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= IDLE;
            starveCnt <= '0;
            m_req     <= 1'b0;
            m_we      <= 1'b0;
            m_addr    <= '0;
            m_wdata   <= '0;
            i_ready   <= 1'b0;
            d_ready   <= 1'b0;
            i_rdata   <= '0;
            d_rdata   <= '0;
        end else begin
            i_ready <= 1'b0;
            d_ready <= 1'b0;
            case (state)
                IDLE: begin
                    if (grantData) begin
                        state   <= DBUSY;
                        m_req   <= 1'b1;
                        m_we    <= d_we;
                        m_addr  <= d_addr;
                        m_wdata <= d_wdata;
                        if (!fetchElig) begin
                            starveCnt <= '0;
                        end else if (starveCnt != CW'(STARVE_LIMIT)) begin
                            starveCnt <= starveCnt + CW'(1);
                        end
                    end else if (grantFetch) begin
                        state     <= IBUSY;
                        m_req     <= 1'b1;
                        m_we      <= 1'b0;
                        m_addr    <= i_addr;
                        m_wdata   <= '0;
                        starveCnt <= '0;
                    end
                end
                IBUSY: begin
                    if (m_ack) begin
                        state   <= IDLE;
                        m_req   <= 1'b0;
                        i_rdata <= m_rdata;
                        i_ready <= 1'b1;
                    end
                end
                DBUSY: begin
                    if (m_ack) begin
                        state   <= IDLE;
                        m_req   <= 1'b0;
                        d_ready <= 1'b1;
                        if (!m_we) begin
                            d_rdata <= m_rdata;
                        end
                    end
                end
                default: begin
                    state <= IDLE;
                    m_req <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: fetch, priority, store wait, starvation, reset.
`timescale 1ns/1ps
module tb_mem_arbiter;

    localparam int unsigned AW = 32;
    localparam int unsigned DW = 32;

    logic          clk;
    logic          reset;
    logic          i_req;
    logic [AW-1:0] i_addr;
    logic [DW-1:0] i_rdata;
    logic          i_ready;
    logic          d_req;
    logic          d_we;
    logic [AW-1:0] d_addr;
    logic [DW-1:0] d_wdata;
    logic [DW-1:0] d_rdata;
    logic          d_ready;
    logic          m_req;
    logic          m_we;
    logic [AW-1:0] m_addr;
    logic [DW-1:0] m_wdata;
    logic [DW-1:0] m_rdata;
    logic          m_ack;

    int checks;
    int errors;

    mem_arbiter #(.AW(AW), .DW(DW), .STARVE_LIMIT(4)) dut (
        .clk(clk), .reset(reset),
        .i_req(i_req), .i_addr(i_addr), .i_rdata(i_rdata), .i_ready(i_ready),
        .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_rdata(d_rdata), .d_ready(d_ready),
        .m_req(m_req), .m_we(m_we), .m_addr(m_addr), .m_wdata(m_wdata),
        .m_rdata(m_rdata), .m_ack(m_ack)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance to just after the next rising edge.
    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    initial begin
        checks  = 0;
        errors  = 0;
        reset   = 1'b0;
        i_req   = 1'b1;
        i_addr  = 32'h100;
        d_req   = 1'b0;
        d_we    = 1'b0;
        d_addr  = '0;
        d_wdata = '0;
        m_rdata = '0;
        m_ack   = 1'b0;
        cyc();
        cyc();
        chk("rst_m_req",   64'(m_req),   64'd0);
        chk("rst_m_we",    64'(m_we),    64'd0);
        chk("rst_m_addr",  64'(m_addr),  64'd0);
        chk("rst_m_wdata", 64'(m_wdata), 64'd0);
        chk("rst_i_ready", 64'(i_ready), 64'd0);
        chk("rst_d_ready", 64'(d_ready), 64'd0);
        chk("rst_i_rdata", 64'(i_rdata), 64'd0);
        chk("rst_d_rdata", 64'(d_rdata), 64'd0);

        // Single fetch, ack in first busy cycle; grant on first edge with reset high.
        reset = 1'b1;
        #2;
        chk("no_grant_before_edge", 64'(m_req), 64'd0);
        cyc();
        chk("fetch_m_req",   64'(m_req),   64'd1);
        chk("fetch_m_addr",  64'(m_addr),  64'h100);
        chk("fetch_m_we",    64'(m_we),    64'd0);
        chk("fetch_m_wdata", 64'(m_wdata), 64'd0);
        m_ack   = 1'b1;
        m_rdata = 32'h8C020004;
        cyc();
        chk("fetch_m_req_drop", 64'(m_req),   64'd0);
        chk("fetch_i_ready",    64'(i_ready), 64'd1);
        chk("fetch_i_rdata",    64'(i_rdata), 64'h8C020004);
        m_ack = 1'b0;
        i_req = 1'b0;
        cyc();
        chk("fetch_i_ready_pulse", 64'(i_ready), 64'd0);
        chk("fetch_idle_m_req",    64'(m_req),   64'd0);

        // Stray ack while idle is ignored.
        m_ack   = 1'b1;
        m_rdata = 32'h11111111;
        cyc();
        chk("idle_ack_i_ready", 64'(i_ready), 64'd0);
        chk("idle_ack_d_ready", 64'(d_ready), 64'd0);
        chk("idle_ack_i_rdata", 64'(i_rdata), 64'h8C020004);
        chk("idle_ack_m_req",   64'(m_req),   64'd0);
        m_ack = 1'b0;

        // Simultaneous requests: data first, fetch granted in the d_ready cycle.
        i_req  = 1'b1;
        i_addr = 32'h104;
        d_req  = 1'b1;
        d_we   = 1'b0;
        d_addr = 32'h200;
        cyc();
        chk("prio_data_m_req",  64'(m_req),  64'd1);
        chk("prio_data_m_addr", 64'(m_addr), 64'h200);
        chk("prio_data_m_we",   64'(m_we),   64'd0);
        m_ack   = 1'b1;
        m_rdata = 32'h12345678;
        cyc();
        chk("prio_d_ready", 64'(d_ready), 64'd1);
        chk("prio_d_rdata", 64'(d_rdata), 64'h12345678);
        chk("prio_gap",     64'(m_req),   64'd0);
        d_req = 1'b0;
        m_ack = 1'b0;
        cyc();
        chk("prio_d_ready_pulse", 64'(d_ready), 64'd0);
        chk("prio_fetch_m_req",   64'(m_req),   64'd1);
        chk("prio_fetch_m_addr",  64'(m_addr),  64'h104);
        chk("prio_fetch_m_we",    64'(m_we),    64'd0);
        m_ack   = 1'b1;
        m_rdata = 32'hCAFEF00D;
        cyc();
        chk("prio_i_ready", 64'(i_ready), 64'd1);
        chk("prio_i_rdata", 64'(i_rdata), 64'hCAFEF00D);
        chk("prio_d_keep",  64'(d_rdata), 64'h12345678);
        i_req = 1'b0;
        m_ack = 1'b0;
        cyc();

        // Store with three memory wait cycles.
        d_req   = 1'b1;
        d_we    = 1'b1;
        d_addr  = 32'h40;
        d_wdata = 32'hDEADBEEF;
        for (int k = 0; k < 4; k++) begin
            cyc();
            chk("st_m_req",   64'(m_req),   64'd1);
            chk("st_m_we",    64'(m_we),    64'd1);
            chk("st_m_addr",  64'(m_addr),  64'h40);
            chk("st_m_wdata", 64'(m_wdata), 64'hDEADBEEF);
            chk("st_no_ready", 64'(d_ready), 64'd0);
            if (k == 0) begin
                d_wdata = 32'h0BADF00D;
                d_addr  = 32'h44;
            end
        end
        m_ack   = 1'b1;
        m_rdata = 32'h55555555;
        cyc();
        chk("st_d_ready",     64'(d_ready), 64'd1);
        chk("st_d_rdata_keep", 64'(d_rdata), 64'h12345678);
        chk("st_m_req_drop",  64'(m_req),   64'd0);
        d_req = 1'b0;
        d_we  = 1'b0;
        m_ack = 1'b0;
        cyc();
        chk("st_d_ready_pulse", 64'(d_ready), 64'd0);

        // Starvation: four data grants with a fetch pending, then fetch wins.
        i_addr = 32'h108;
        d_addr = 32'h300;
        d_req  = 1'b1;
        for (int k = 0; k < 4; k++) begin
            i_req = 1'b1;
            cyc();
            chk("starve_data_addr", 64'(m_addr), 64'h300);
            chk("starve_data_req",  64'(m_req),  64'd1);
            i_req   = 1'b0;
            m_ack   = 1'b1;
            m_rdata = 32'(k + 1);
            cyc();
            chk("starve_d_ready", 64'(d_ready), 64'd1);
            chk("starve_d_rdata", 64'(d_rdata), 64'(k + 1));
            m_ack = 1'b0;
            cyc();
            chk("starve_idle", 64'(m_req), 64'd0);
        end
        chk("starve_cnt_full", 64'(dut.starveCnt), 64'd4);
        i_req = 1'b1;
        cyc();
        chk("starve_fetch_addr", 64'(m_addr), 64'h108);
        chk("starve_fetch_we",   64'(m_we),   64'd0);
        chk("starve_cnt_clear",  64'(dut.starveCnt), 64'd0);
        m_ack   = 1'b1;
        m_rdata = 32'hAAAA5555;
        cyc();
        chk("starve_i_ready", 64'(i_ready), 64'd1);
        chk("starve_i_rdata", 64'(i_rdata), 64'hAAAA5555);
        i_req = 1'b0;
        m_ack = 1'b0;
        cyc();
        chk("mid_dbusy_m_req",  64'(m_req),  64'd1);
        chk("mid_dbusy_m_addr", 64'(m_addr), 64'h300);

        // Reset during an outstanding data access.
        reset = 1'b0;
        m_ack = 1'b1;
        #1;
        chk("mr_m_req",   64'(m_req),   64'd0);
        chk("mr_m_addr",  64'(m_addr),  64'd0);
        chk("mr_m_we",    64'(m_we),    64'd0);
        chk("mr_m_wdata", 64'(m_wdata), 64'd0);
        chk("mr_d_rdata", 64'(d_rdata), 64'd0);
        chk("mr_i_rdata", 64'(i_rdata), 64'd0);
        chk("mr_d_ready", 64'(d_ready), 64'd0);
        chk("mr_i_ready", 64'(i_ready), 64'd0);
        cyc();
        d_req = 1'b0;
        reset = 1'b1;
        for (int k = 0; k < 3; k++) begin
            cyc();
            chk("mr_after_d_ready", 64'(d_ready), 64'd0);
            chk("mr_after_m_req",   64'(m_req),   64'd0);
            m_ack = 1'b0;
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
